// File: rtl/clf_head_mac_scheduler.sv
// Classifier-head scheduler: drives one shared MAC through bias load plus E multiply-accumulates
// per class, then streams each finished logit out through a single valid/ready output slot.
module clf_head_mac_scheduler #(
    parameter int unsigned E           = 128,
    parameter int unsigned NUM_CLASSES = 1000,
    parameter int unsigned ACC_WIDTH   = 32,
    localparam int unsigned XW = (E > 1) ? $clog2(E) : 1,
    localparam int unsigned WW = (E * NUM_CLASSES > 1) ? $clog2(E * NUM_CLASSES) : 1,
    localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [XW-1:0]        x_addr,
    output logic [WW-1:0]        w_addr,
    output logic [CW-1:0]        b_addr,
    output logic                 mac_load,
    output logic                 mac_en,
    input  logic [ACC_WIDTH-1:0] acc_in,
    output logic                 logit_valid,
    input  logic                 logit_ready,
    output logic [ACC_WIDTH-1:0] logit_data,
    output logic [CW-1:0]        logit_class,
    output logic                 logit_last
);

    typedef enum logic [2:0] {StIdle, StBias, StMac, StPipe, StCap, StFlush} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        c_q, c_d;
    logic [XW-1:0]        e_q, e_d;
    logic [WW-1:0]        w_off_q, w_off_d;
    logic                 mac_load_q, mac_en_q;
    logic                 valid_q;
    logic [ACC_WIDTH-1:0] data_q;
    logic [CW-1:0]        class_q;
    logic                 last_q;
    logic                 fire, slot_free, load_slot;

    assign fire      = valid_q && logit_ready;
    assign slot_free = !valid_q || logit_ready;

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        e_d       = e_q;
        w_off_d   = w_off_q;
        load_slot = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBias;
                    c_d     = '0;
                end
            end
            StBias: begin
                state_d = StMac;
                e_d     = '0;
                w_off_d = WW'(c_q);
            end
            StMac: begin
                // Weight address walks down column c in strides of NUM_CLASSES.
                if (e_q == XW'(E - 1)) begin
                    state_d = StPipe;
                end else begin
                    e_d     = e_q + 1'b1;
                    w_off_d = w_off_q + WW'(NUM_CLASSES);
                end
            end
            StPipe: state_d = StCap;
            StCap: begin
                // No reads or strobes while waiting, so the accumulator holds its value.
                if (slot_free) begin
                    load_slot = 1'b1;
                    if (c_q == CW'(NUM_CLASSES - 1)) begin
                        state_d = StFlush;
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = StBias;
                    end
                end
            end
            StFlush: begin
                if (fire) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        mem_rd_en = (state_q == StBias) || (state_q == StMac);
        b_addr    = (state_q == StBias) ? c_q : '0;
        x_addr    = (state_q == StMac) ? e_q : '0;
        w_addr    = (state_q == StMac) ? w_off_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            c_q        <= '0;
            e_q        <= '0;
            w_off_q    <= '0;
            mac_load_q <= 1'b0;
            mac_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            class_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            e_q        <= e_d;
            w_off_q    <= w_off_d;
            // SRAM data lands one cycle after the read, so strobes trail the read by one cycle.
            mac_load_q <= (state_q == StBias);
            mac_en_q   <= (state_q == StMac);
            if (load_slot) begin
                valid_q <= 1'b1;
                data_q  <= acc_in;
                class_q <= c_q;
                last_q  <= (c_q == CW'(NUM_CLASSES - 1));
            end else if (fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign mac_load    = mac_load_q;
    assign mac_en      = mac_en_q;
    assign logit_valid = valid_q;
    assign logit_data  = data_q;
    assign logit_class = class_q;
    assign logit_last  = last_q;

endmodule

// File: tb/tb_clf_head_mac_scheduler.sv
// Bench for clf_head_mac_scheduler: SRAM and MAC models around two DUT configurations,
// logits checked against a direct dot-product reference.
module tb_clf_head_mac_scheduler;

    localparam int EA = 4;
    localparam int NA = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Configuration A: E=4, NUM_CLASSES=3
    logic        start_a, busy_a, done_a, mem_rd_en_a, mac_load_a, mac_en_a;
    logic [1:0]  x_addr_a, b_addr_a, logit_class_a;
    logic [3:0]  w_addr_a;
    logic [31:0] logit_data_a;
    logic        logit_valid_a, logit_ready_a, logit_last_a;
    logic signed [31:0] acc_a, xd_a, wd_a, bd_a;

    clf_head_mac_scheduler #(.E(EA), .NUM_CLASSES(NA), .ACC_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(mem_rd_en_a), .x_addr(x_addr_a), .w_addr(w_addr_a), .b_addr(b_addr_a),
        .mac_load(mac_load_a), .mac_en(mac_en_a), .acc_in(acc_a),
        .logit_valid(logit_valid_a), .logit_ready(logit_ready_a), .logit_data(logit_data_a),
        .logit_class(logit_class_a), .logit_last(logit_last_a)
    );

    // Configuration B: E=1, NUM_CLASSES=1
    logic        start_b, busy_b, done_b, mem_rd_en_b, mac_load_b, mac_en_b;
    logic [0:0]  x_addr_b, w_addr_b, b_addr_b, logit_class_b;
    logic [31:0] logit_data_b;
    logic        logit_valid_b, logit_ready_b, logit_last_b;
    logic signed [31:0] acc_b, xd_b, wd_b, bd_b;

    clf_head_mac_scheduler #(.E(1), .NUM_CLASSES(1), .ACC_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(mem_rd_en_b), .x_addr(x_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b),
        .mac_load(mac_load_b), .mac_en(mac_en_b), .acc_in(acc_b),
        .logit_valid(logit_valid_b), .logit_ready(logit_ready_b), .logit_data(logit_data_b),
        .logit_class(logit_class_b), .logit_last(logit_last_b)
    );

    int xa [EA];
    int wa [EA][NA];
    int ba [NA];
    int xb, wb, bb;

    // SRAM (1-cycle read latency) and MAC behaviour
    always @(posedge clk) begin
        if (mem_rd_en_a) begin
            xd_a <= xa[x_addr_a];
            wd_a <= wa[int'(w_addr_a) / NA][int'(w_addr_a) % NA];
            bd_a <= ba[b_addr_a];
        end
        if (mac_load_a) acc_a <= bd_a;
        else if (mac_en_a) acc_a <= acc_a + xd_a * wd_a;
        if (mem_rd_en_b) begin
            xd_b <= xb;
            wd_b <= wb;
            bd_b <= bb;
        end
        if (mac_load_b) acc_b <= bd_b;
        else if (mac_en_b) acc_b <= acc_b + xd_b * wd_b;
    end

    function automatic int ref_a(int c);
        int s = ba[c];
        for (int e = 0; e < EA; e++) s += xa[e] * wa[e][c];
        return s;
    endfunction

    typedef struct {int cls; logic [31:0] data; logic last;} hs_t;
    hs_t got_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk1({tag, "_busy"}, busy_a, 1'b0);
        chk1({tag, "_done"}, done_a, 1'b0);
        chk1({tag, "_rd"}, mem_rd_en_a, 1'b0);
        chk1({tag, "_load"}, mac_load_a, 1'b0);
        chk1({tag, "_en"}, mac_en_a, 1'b0);
        chk1({tag, "_valid"}, logit_valid_a, 1'b0);
        chk1({tag, "_last"}, logit_last_a, 1'b0);
        chk32({tag, "_xaddr"}, 32'(x_addr_a), 32'd0);
        chk32({tag, "_waddr"}, 32'(w_addr_a), 32'd0);
        chk32({tag, "_baddr"}, 32'(b_addr_a), 32'd0);
        chk32({tag, "_data"}, logit_data_a, 32'd0);
        chk32({tag, "_class"}, 32'(logit_class_a), 32'd0);
    endtask

    // One pass on configuration A; cycle 0 is the cycle start is driven.
    task automatic run_pass_a(input int exp_done, input int lo_from, input int lo_len,
                              input bit rnd_ready, input bit start_all, input int rst_at);
        int j = 0;
        int dones = 0;
        int done_cyc = -1;
        int win_reads = 0;
        int prev_kind = 0;
        int kind;
        logic pv_stall = 1'b0;
        logic [31:0] pv_data = '0;
        logic [1:0] pv_class = '0;
        got_q.delete();
        start_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                step();
                start_a = start_all;
            end
            logit_ready_a = rnd_ready ? ($urandom_range(0, 3) != 0)
                                      : !(k >= lo_from && k < lo_from + lo_len);
            rst_n = (k != rst_at);
            #1;
            chk1("busy", busy_a, k > 0);
            kind = 0;
            if (mem_rd_en_a) begin
                kind = (j % (EA + 1) == 0) ? 1 : 2;
                if (kind == 1) begin
                    chk32("b_addr", 32'(b_addr_a), j / (EA + 1));
                end else begin
                    chk32("x_addr", 32'(x_addr_a), j % (EA + 1) - 1);
                    chk32("w_addr", 32'(w_addr_a), (j % (EA + 1) - 1) * NA + j / (EA + 1));
                end
                if (k >= lo_from && k < lo_from + lo_len) win_reads++;
                j++;
            end
            chk1("mac_load_lag", mac_load_a, prev_kind == 1);
            chk1("mac_en_lag", mac_en_a, prev_kind == 2);
            prev_kind = kind;
            if (pv_stall) begin
                chk1("hold_valid", logit_valid_a, 1'b1);
                chk32("hold_data", logit_data_a, pv_data);
                chk32("hold_class", 32'(logit_class_a), 32'(pv_class));
            end
            pv_stall = logit_valid_a && !logit_ready_a;
            pv_data  = logit_data_a;
            pv_class = logit_class_a;
            if (logit_valid_a && logit_ready_a)
                got_q.push_back('{int'(logit_class_a), logit_data_a, logit_last_a});
            if (done_a) begin
                dones++;
                done_cyc = k;
                chk1("done_with_hs", logit_valid_a && logit_ready_a, 1'b1);
                chk1("done_last", logit_last_a, 1'b1);
            end
            if (done_a || k == rst_at) break;
        end
        if (rst_at >= 0) begin
            step();
            rst_n = 1'b1;
            #1;
            chk_idle_a("after_rst");
            repeat (3) begin
                step();
                #1;
                chk1("rst_no_done", done_a, 1'b0);
                chk1("rst_idle", busy_a, 1'b0);
            end
            chk32("rst_done_count", dones, 0);
        end else begin
            chk32("done_count", dones, 1);
            if (exp_done >= 0) chk32("done_cycle", done_cyc, exp_done);
            chk32("read_count", j, NA * (EA + 1));
            if (lo_len > 0) chk32("stall_reads", win_reads, EA + 1);
            chk32("n_logits", got_q.size(), NA);
            foreach (got_q[i]) begin
                chk32("logit_class", got_q[i].cls, i);
                chk32("logit_data", got_q[i].data, ref_a(i));
                chk1("logit_last", got_q[i].last, i == NA - 1);
            end
        end
    endtask

    task automatic load_t1_data();
        for (int e = 0; e < EA; e++) begin
            xa[e] = e + 1;
            for (int c = 0; c < NA; c++) wa[e][c] = c + 1;
        end
        for (int c = 0; c < NA; c++) ba[c] = 10 * c;
    endtask

    initial begin
        int dones_b;
        int hs_b;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        logit_ready_a = 1'b1;
        logit_ready_b = 1'b1;
        xb = 0; wb = 0; bb = 0;
        load_t1_data();
        step();
        step();
        chk_idle_a("reset");
        chk1("reset_b_busy", busy_b, 1'b0);
        chk1("reset_b_valid", logit_valid_b, 1'b0);
        chk1("reset_b_last", logit_last_b, 1'b0);
        chk1("reset_b_rd", mem_rd_en_b, 1'b0);
        rst_n = 1'b1;
        step();

        // Directed data, no backpressure
        run_pass_a(NA * (EA + 3) + 1, 0, 0, 1'b0, 1'b0, -1);
        step();
        chk1("post_busy", busy_a, 1'b0);
        chk1("post_valid", logit_valid_a, 1'b0);

        // Ready low from first valid until class 1 has sat in capture for EA+4 cycles
        run_pass_a(NA * (EA + 3) + 1 + (EA + 4), EA + 4, 2 * (EA + 3), 1'b0, 1'b0, -1);
        step();

        // start held high throughout
        run_pass_a(NA * (EA + 3) + 1, 0, 0, 1'b0, 1'b1, -1);
        step();
        chk1("t4_idle_busy", busy_a, 1'b0);
        chk1("t4_idle_done", done_a, 1'b0);
        step();
        chk1("t4_restart_busy", busy_a, 1'b1);
        chk1("t4_restart_rd", mem_rd_en_a, 1'b1);
        chk32("t4_restart_baddr", 32'(b_addr_a), 32'd0);
        start_a = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of class 1 accumulation, then a clean rerun
        run_pass_a(-1, 0, 0, 1'b0, 1'b0, 1 + (EA + 3) + 2);
        run_pass_a(NA * (EA + 3) + 1, 0, 0, 1'b0, 1'b0, -1);
        step();

        // Random signed data under random backpressure
        repeat (3) begin
            for (int e = 0; e < EA; e++) begin
                xa[e] = int'($urandom_range(0, 255)) - 128;
                for (int c = 0; c < NA; c++) wa[e][c] = int'($urandom_range(0, 255)) - 128;
            end
            for (int c = 0; c < NA; c++) ba[c] = int'($urandom_range(0, 2000)) - 1000;
            run_pass_a(-1, 0, 0, 1'b1, 1'b0, -1);
            step();
        end
        logit_ready_a = 1'b1;

        // Single-element, single-class configuration with negative operands
        xb = -2; wb = 3; bb = -1;
        dones_b = 0;
        hs_b = 0;
        start_b = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) begin
                step();
                start_b = 1'b0;
            end
            #1;
            if (logit_valid_b && logit_ready_b) begin
                hs_b++;
                chk32("b_logit", logit_data_b, 32'(bb + xb * wb));
                chk32("b_class", 32'(logit_class_b), 32'd0);
                chk1("b_last", logit_last_b, 1'b1);
            end
            if (done_b) begin
                dones_b++;
                chk32("b_done_cycle", k, 1 * (1 + 3) + 1);
                break;
            end
        end
        chk32("b_done_count", dones_b, 1);
        chk32("b_handshakes", hs_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
